// File: rtl/multi_clk_div.sv
// Multi-channel programmable clock divider: NUM_CH independent 50%-duty outputs with tick strobes,
// shadowed divisor updates that only take effect at a half-period boundary, and a common phase sync.
module multi_clk_div #(
    parameter int NUM_CH    = 4,
    parameter int CNT_W     = 17,
    parameter int DIV_RESET = 104166
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic [NUM_CH-1:0]       load,
    input  logic [NUM_CH*CNT_W-1:0] div_in,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       pending
);

    localparam logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_RESET);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div_act;
        logic [CNT_W-1:0] div_shd;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             tc;

        assign tc = en[g] && (cnt == div_act);

        // The load capture sits after the priority chain so a same-edge load wins over the pend
        // clear, while the transfer into div_act still sees the old shadow value.
        always_ff @(posedge clk_in or negedge reset) begin
            if (!reset) begin
                cnt     <= '0;
                div_act <= DIV_INIT;
                div_shd <= DIV_INIT;
                pend    <= 1'b0;
                clk_q   <= 1'b0;
                tick_q  <= 1'b0;
            end else begin
                if (!en[g]) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        div_act <= div_shd;
                        pend    <= 1'b0;
                    end
                end else if (sync) begin
                    cnt    <= '0;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                end else if (tc) begin
                    cnt    <= '0;
                    clk_q  <= ~clk_q;
                    tick_q <= ~clk_q;
                    if (pend) begin
                        div_act <= div_shd;
                        pend    <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt + 1'b1;
                    tick_q <= 1'b0;
                end

                if (load[g]) begin
                    div_shd <= div_in[g*CNT_W +: CNT_W];
                    pend    <= 1'b1;
                end
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
        assign pending[g] = pend;
    end

endmodule
